// File: rtl/mem_access_stage_pkg.sv
// Shared constants, state type and decode helpers for the memory access stage.
package mem_access_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_supported(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    if ((f3 == F3_H) || (f3 == F3_HU)) bad = lo[0];
    else if (f3 == F3_W)               bad = |lo;
    else                               bad = 1'b0;
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port: req/gnt address phase, rvalid read-data phase.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_lane_fmt.sv
// Byte-lane steering: store byte enables / replicated write data, load extraction
// and sign/zero extension. Purely combinational.
module mem_lane_fmt
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] sdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half and build both store and load views.
  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];
    be_o     = 4'b1111;
    wdata_o  = sdata_i;
    load_o   = rdata_i;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{sdata_i[7:0]}};
        load_o  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
        load_o  = {{16{half_sel[15]}}, half_sel};
      end
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues loads/stores on the data-memory port,
// formats load data, registers the writeback result and stalls execute while
// an access is in flight. Define MEM_MISALIGN_TRAP_EN to reject misaligned
// half/word accesses with an error pulse instead of issuing them.
//
// state   | meaning
// IDLE    | waiting for an execute result
// ADDR    | request held on the memory port until gnt
// RESP    | load granted, waiting for rvalid
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic [6:0]          ex_opcode,
  input  logic [2:0]          ex_funct3,
  input  logic [4:0]          ex_rd,
  input  logic [31:0]         ex_addr,
  input  logic [31:0]         ex_data,
  output logic                stall_o,
  mem_access_stage_if.master  dmem,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic [31:0]         mem_forward,
  output logic                mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               store_q;
  logic [2:0]         f3_q;
  logic [4:0]         rd_q;
  logic [31:0]        addr_q;
  logic [31:0]        data_q;
  logic               wb_valid_q, wb_we_q, mem_err_q;
  logic [4:0]         wb_rd_q;
  logic [31:0]        wb_data_q;

  logic               is_load_in, is_store_in, is_mem_in, f3_ok, trap;
  logic               timeout, req;
  logic [3:0]         be_fmt;
  logic [31:0]        wdata_fmt, load_fmt;

  mem_lane_fmt u_lane_fmt (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .rdata_i  (dmem.dmem_rdata),
    .sdata_i  (data_q),
    .be_o     (be_fmt),
    .wdata_o  (wdata_fmt),
    .load_o   (load_fmt)
  );

  // Decode the incoming execute result; misalignment only matters when trapping.
  always_comb begin
    is_load_in  = (ex_opcode == OP_LOAD);
    is_store_in = (ex_opcode == OP_STORE);
    is_mem_in   = is_load_in | is_store_in;
    f3_ok       = f3_supported(is_store_in, ex_funct3);
`ifdef MEM_MISALIGN_TRAP_EN
    trap        = f3_ok & misaligned(ex_funct3, ex_addr[1:0]);
`else
    trap        = 1'b0;
`endif
    timeout     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Sequencer: accept, hold request, collect response, retire or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      f3_q       <= 3'd0;
      rd_q       <= 5'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      mem_err_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      mem_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!is_mem_in) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= (ex_rd != 5'd0);
              wb_rd_q    <= ex_rd;
              wb_data_q  <= ex_data;
            end else if (!f3_ok || trap) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_rd_q    <= ex_rd;
              mem_err_q  <= trap;
            end else begin
              store_q <= is_store_in;
              f3_q    <= ex_funct3;
              rd_q    <= ex_rd;
              addr_q  <= ex_addr;
              data_q  <= ex_data;
              cnt_q   <= '0;
              state_q <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (dmem.dmem_gnt) begin
            cnt_q <= '0;
            if (store_q) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_rd_q    <= rd_q;
              state_q    <= ST_IDLE;
            end else if (dmem.dmem_rvalid) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= (rd_q != 5'd0);
              wb_rd_q    <= rd_q;
              wb_data_q  <= load_fmt;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_RESP;
            end
          end else if (timeout) begin
            cnt_q      <= '0;
            mem_err_q  <= 1'b1;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= rd_q;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (dmem.dmem_rvalid) begin
            cnt_q      <= '0;
            wb_valid_q <= 1'b1;
            wb_we_q    <= (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= load_fmt;
            state_q    <= ST_IDLE;
          end else if (timeout) begin
            cnt_q      <= '0;
            mem_err_q  <= 1'b1;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= rd_q;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Port drive straight from state so reset drops the request immediately.
  always_comb begin
    req             = (state_q == ST_ADDR);
    stall_o         = (state_q != ST_IDLE) | (ex_valid & is_mem_in);
    dmem.dmem_req   = req;
    dmem.dmem_we    = req & store_q;
    dmem.dmem_be    = req ? be_fmt : 4'd0;
    dmem.dmem_addr  = req ? {addr_q[31:2], 2'b00} : 32'd0;
    dmem.dmem_wdata = req ? wdata_fmt : 32'd0;
    wb_valid        = wb_valid_q;
    wb_we           = wb_we_q;
    wb_rd           = wb_rd_q;
    wb_data         = wb_data_q;
    mem_forward     = wb_data_q;
    mem_err         = mem_err_q;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases then randomized
// transactions against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_opcode = 7'd0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_data = 32'd0;
  logic        stall_o, wb_valid, wb_we, mem_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_forward;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_wb_data = 32'd0;

  mem_access_stage_if dmem_if ();

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_addr(ex_addr), .ex_data(ex_data),
    .stall_o(stall_o), .dmem(dmem_if),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_forward(mem_forward), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_supported(input bit is_st, input logic [2:0] f3);
    if (is_st) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    int size;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (a % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd_word);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd_word >> (8 * a[1:0])) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (rd_word >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = rd_word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd0) return 32'd1 << a[1:0];
    if (f3 == 3'd1) return a[1] ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One instruction from accept to retire; called at posedge+1.
  // gnt arrives gnt_dly request cycles late, rvalid rv_dly cycles after gnt.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    bit is_ld, is_st, is_mem, issue, err, exp_we;
    int g, ret, req_last;
    logic [31:0] exp_data;
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    is_mem = is_ld | is_st;
    issue  = is_mem && ref_supported(is_st, f3) && !ref_trap(f3, addr);
    g = gnt_dly + 1;
    err = 0; exp_we = 0; req_last = 0; ret = 1;
    exp_data = exp_wb_data;
    if (!is_mem) begin
      exp_we = (rd != 0); exp_data = data;
    end else if (!issue) begin
      err = is_mem && ref_supported(is_st, f3);
    end else if (g > TO) begin
      req_last = TO; ret = TO + 1; err = 1;
    end else begin
      req_last = g;
      if (is_st) ret = g + 1;
      else if (rv_dly > TO) begin ret = g + TO + 1; err = 1; end
      else begin
        ret = g + rv_dly + 1; exp_we = (rd != 0); exp_data = ref_load(f3, addr, rdata);
      end
    end
    for (int k = 0; k <= ret; k++) begin
      ex_valid = (k == 0);
      if (k == 0) begin
        ex_opcode = op; ex_funct3 = f3; ex_rd = rd; ex_addr = addr; ex_data = data;
      end
      dmem_if.dmem_gnt    = issue && (k == g);
      dmem_if.dmem_rvalid = issue && is_ld && (k == g + rv_dly);
      dmem_if.dmem_rdata  = rdata;
      @(negedge clk);
      chk("stall", 32'(stall_o), (k == 0) ? 32'(is_mem) : 32'(k < ret));
      chk("req", 32'(dmem_if.dmem_req), 32'(issue && k >= 1 && k <= req_last));
      if (issue && k >= 1 && k <= req_last) begin
        chk("addr", dmem_if.dmem_addr, addr & 32'hFFFF_FFFC);
        chk("we", 32'(dmem_if.dmem_we), 32'(is_st));
        if (is_st) begin
          chk("be", 32'(dmem_if.dmem_be), ref_be(f3, addr));
          chk("wdata", dmem_if.dmem_wdata, ref_wdata(f3, data));
        end
      end
      chk("wb_valid", 32'(wb_valid), 32'(k == ret));
      chk("mem_err", 32'(mem_err), 32'(k == ret && err));
      if (k == ret) begin
        chk("wb_we", 32'(wb_we), 32'(exp_we));
        chk("wb_data", wb_data, exp_data);
        chk("mem_forward", mem_forward, exp_data);
        if (exp_we) chk("wb_rd", 32'(wb_rd), 32'(rd));
      end
      @(posedge clk);
      #1;
    end
    exp_wb_data = exp_data;
    dmem_if.dmem_gnt = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;
  endtask

  initial begin
    dmem_if.dmem_gnt = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;
    dmem_if.dmem_rdata = 32'd0;
    #3;
    chk("rst_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_txn(7'b0010011, 3'd0, 5'd5, 32'd0, 32'h1234, 32'd0, 0, 0);
    run_txn(7'b0000011, 3'd0, 5'd7, 32'h103, 32'd0, 32'h80FF_0000, 2, 1);
    run_txn(7'b0100011, 3'd1, 5'd0, 32'h202, 32'h0000_ABCD, 32'd0, 1, 0);
    run_txn(7'b0000011, 3'd2, 5'd0, 32'h40, 32'd0, 32'hDEAD_BEEF, 0, 0);
    run_txn(7'b0100011, 3'd2, 5'd3, 32'h80, 32'h5555_AAAA, 32'd0, 40, 0);
    run_txn(7'b0000011, 3'd4, 5'd9, 32'h11, 32'd0, 32'h0000_F600, 15, 2);
    run_txn(7'b0000011, 3'd5, 5'd9, 32'h12, 32'd0, 32'h8001_0000, 0, 17);
    run_txn(7'b0000011, 3'd3, 5'd4, 32'h20, 32'd0, 32'd0, 0, 0);
    run_txn(7'b0100011, 3'd5, 5'd4, 32'h24, 32'h77, 32'd0, 0, 0);
    run_txn(7'b0000011, 3'd2, 5'd6, 32'h33, 32'd0, 32'hCAFE_F00D, 1, 1);

    // randomized transactions
    for (int n = 0; n < 60; n++) begin
      int r, gd, rv;
      logic [6:0] op;
      r  = $urandom_range(0, 7);
      op = (r < 2) ? 7'b0010011 : (r < 3) ? 7'b0110011 : (r < 6) ? 7'b0000011 : 7'b0100011;
      gd = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
      rv = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 3);
      run_txn(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom,
              $urandom, gd, rv);
    end

    // reset while a load waits in RESP; late rvalid must be ignored
    ex_valid = 1'b1; ex_opcode = 7'b0000011; ex_funct3 = 3'd2; ex_rd = 5'd8;
    ex_addr = 32'h40;
    @(posedge clk); #1;
    ex_valid = 1'b0; dmem_if.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_if.dmem_gnt = 1'b0;
    #2;
    chk("resp_stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_req", 32'(dmem_if.dmem_req), 32'd0);
    chk("rst_async_stall", 32'(stall_o), 32'd0);
    chk("rst_async_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_if.dmem_rvalid = 1'b1;
    dmem_if.dmem_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_rvalid_wb_valid", 32'(wb_valid), 32'd0);
      chk("late_rvalid_stall", 32'(stall_o), 32'd0);
      chk("late_rvalid_wb_data", wb_data, 32'd0);
      @(posedge clk); #1;
      dmem_if.dmem_rvalid = 1'b0;
    end
    exp_wb_data = 32'd0;
    run_txn(7'b0010011, 3'd0, 5'd1, 32'd0, 32'h0BAD_F00D, 32'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
